// File: rtl/imem_loader_if.sv
// Valid/ready word stream feeding the instruction-memory loader.
// The master is the boot/program source and the slave is the loader.
interface imem_loader_if #(
    parameter int DATA_BITS = 32
) ();
    logic                 in_valid;
    logic [DATA_BITS-1:0] in_data;
    logic                 in_last;
    logic                 in_ready;

    modport master (output in_valid, in_data, in_last, input in_ready);
    modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide memory, big-endian, 4 bytes per word.
// Optional running checksum output is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 32,
    parameter int MEM_BYTES     = 80,
    parameter int BASE_ADDR     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    imem_loader_if.slave             stream,
    output logic                     mem_we,
    output logic [RAM_ADDR_BITS-1:0] mem_addr,
    output logic [RAM_WIDTH-1:0]     mem_wdata,
    output logic [15:0]              word_count,
    output logic                     load_done,
    output logic                     load_err
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]              checksum
`endif
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE, ERROR} state_t;

    localparam logic [RAM_ADDR_BITS:0] LIMIT = (RAM_ADDR_BITS+1)'(BASE_ADDR + MEM_BYTES);

    state_t                   state, state_n;
    logic [RAM_ADDR_BITS-1:0] word_q;
    logic [RAM_ADDR_BITS-1:0] ptr;
    logic                     last_q;
    logic [1:0]               idx;
    logic                     accept;
    logic                     overflow;
    logic                     mem_we_n;
    logic [RAM_ADDR_BITS-1:0] mem_addr_n;
    logic [RAM_WIDTH-1:0]     mem_wdata_n;

    // Byte idx of a word, idx 0 being the most significant byte.
    function automatic logic [RAM_WIDTH-1:0] pick(input logic [RAM_ADDR_BITS-1:0] w,
                                                  input logic [1:0] i);
        return w[(RAM_ADDR_BITS-1) - RAM_WIDTH*int'(i) -: RAM_WIDTH];
    endfunction

    assign accept   = (state == IDLE) && stream.in_valid;
    assign overflow = ({1'b0, ptr} + (RAM_ADDR_BITS+1)'(4)) > LIMIT;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = overflow ? ERROR : WRITE;
            WRITE:   if (idx == 2'd3) state_n = last_q ? DONE : IDLE;
            default: state_n = state;
        endcase
    end

    // Computes the values the registered write port takes at the next edge,
    // so the first byte shows up the cycle right after acceptance.
    always_comb begin
        stream.in_ready = (state == IDLE) && !rst;
        mem_we_n        = 1'b0;
        mem_addr_n      = mem_addr;
        mem_wdata_n     = mem_wdata;
        case (state)
            IDLE: begin
                if (accept && !overflow) begin
                    mem_we_n    = 1'b1;
                    mem_addr_n  = ptr;
                    mem_wdata_n = pick(stream.in_data, 2'd0);
                end
            end
            WRITE: begin
                if (idx != 2'd3) begin
                    mem_we_n    = 1'b1;
                    mem_addr_n  = ptr + RAM_ADDR_BITS'(idx) + RAM_ADDR_BITS'(1);
                    mem_wdata_n = pick(word_q, idx + 2'd1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q     <= '0;
            last_q     <= 1'b0;
            idx        <= 2'd0;
            ptr        <= RAM_ADDR_BITS'(BASE_ADDR);
            word_count <= 16'd0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum   <= 32'd0;
`endif
        end else begin
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            case (state)
                IDLE: begin
                    if (accept) begin
                        word_q <= stream.in_data;
                        last_q <= stream.in_last;
                        idx    <= 2'd0;
                        if (overflow) load_err <= 1'b1;
                    end
                end
                WRITE: begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        ptr <= ptr + RAM_ADDR_BITS'(4);
                        if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
                        if (last_q) load_done <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        checksum <= checksum + 32'(word_q);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: one default instance and one small, offset instance
// (MEM_BYTES=8, BASE_ADDR=16) checked against an image-level reference model.
module tb_imem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_v;
    logic [1:0]  valid_v;
    logic [1:0]  last_v;
    logic [31:0] data;
    logic [1:0]  ready_v, we_v, done_v, err_v;
    logic [31:0] addr_v [2];
    logic [7:0]  wdata_v [2];
    logic [15:0] wc_v [2];
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] cks_v [2];
`endif

    imem_loader_if #(.DATA_BITS(32)) if_a ();
    imem_loader_if #(.DATA_BITS(32)) if_b ();

    assign if_a.in_valid = valid_v[0];
    assign if_a.in_data  = data;
    assign if_a.in_last  = last_v[0];
    assign ready_v[0]    = if_a.in_ready;
    assign if_b.in_valid = valid_v[1];
    assign if_b.in_data  = data;
    assign if_b.in_last  = last_v[1];
    assign ready_v[1]    = if_b.in_ready;

    imem_loader #(.RAM_WIDTH(8), .RAM_ADDR_BITS(32), .MEM_BYTES(80), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst(rst_v[0]), .stream(if_a),
        .mem_we(we_v[0]), .mem_addr(addr_v[0]), .mem_wdata(wdata_v[0]),
        .word_count(wc_v[0]), .load_done(done_v[0]), .load_err(err_v[0])
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(cks_v[0])
`endif
    );

    imem_loader #(.RAM_WIDTH(8), .RAM_ADDR_BITS(32), .MEM_BYTES(8), .BASE_ADDR(16)) dut_b (
        .clk(clk), .rst(rst_v[1]), .stream(if_b),
        .mem_we(we_v[1]), .mem_addr(addr_v[1]), .mem_wdata(wdata_v[1]),
        .word_count(wc_v[1]), .load_done(done_v[1]), .load_err(err_v[1])
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(cks_v[1])
`endif
    );

    function automatic int base_of(input int sel);
        return (sel != 0) ? 16 : 0;
    endfunction

    function automatic int mem_of(input int sel);
        return (sel != 0) ? 8 : 80;
    endfunction

    // Observed memory contents and write statistics, per instance.
    logic [7:0]  mem_obs [2][0:127];
    int unsigned n_writes [2] = '{0, 0};
    int unsigned n_oob [2]    = '{0, 0};
    logic [31:0] last_wr [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (we_v[d] === 1'b1) begin
                mem_obs[d][addr_v[d][6:0]] <= wdata_v[d];
                n_writes[d] <= n_writes[d] + 1;
                last_wr[d]  <= addr_v[d];
                if (int'(addr_v[d]) < base_of(d) || int'(addr_v[d]) >= base_of(d) + mem_of(d))
                    n_oob[d] <= n_oob[d] + 1;
            end
        end
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] img [32];

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset(input int sel);
        @(negedge clk);
        rst_v[sel]   = 1'b1;
        valid_v[sel] = 1'b0;
        @(negedge clk);
        check_output("ready_in_reset", 32'(ready_v[sel]), 32'd0);
        rst_v[sel] = 1'b0;
        @(negedge clk);
        check_output("rst_ready", 32'(ready_v[sel]), 32'd1);
        check_output("rst_we", 32'(we_v[sel]), 32'd0);
        check_output("rst_addr", addr_v[sel], 32'd0);
        check_output("rst_wdata", 32'(wdata_v[sel]), 32'd0);
        check_output("rst_wc", 32'(wc_v[sel]), 32'd0);
        check_output("rst_done", 32'(done_v[sel]), 32'd0);
        check_output("rst_err", 32'(err_v[sel]), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_output("rst_cks", cks_v[sel], 32'd0);
`endif
    endtask

    // Offers one word, waits (bounded) for the handshake, then lets the 4 write cycles elapse.
    task automatic apply_stimulus(input int sel, input logic [31:0] w, input logic last,
                                  input bit exp_write, input int exp_addr);
        int waited = 0;
        @(negedge clk);
        data         = w;
        last_v[sel]  = last;
        valid_v[sel] = 1'b1;
        while (ready_v[sel] !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check_output("accept_wait", 32'(waited < 40), 32'd1);
        if (waited >= 40) begin
            valid_v[sel] = 1'b0;
            return;
        end
        @(negedge clk);
        valid_v[sel] = 1'b0;
        data         = $urandom;
        last_v[sel]  = 1'($urandom_range(0, 1));
        check_output("ready_drop", 32'(ready_v[sel]), 32'd0);
        check_output("first_byte_we", 32'(we_v[sel]), 32'(exp_write));
        if (exp_write) check_output("first_byte_addr", addr_v[sel], 32'(exp_addr));
        repeat (4) @(negedge clk);
    endtask

    // Reference: words land at base+4*i while they fit; the first that does not fit
    // goes to ERROR, a fitting word flagged last ends the image.
    task automatic run_image(input int sel, input int n, input int last_idx, input int gap);
        int          cap     = mem_of(sel) / 4;
        int          base    = base_of(sel);
        int          written = 0;
        bit          exp_done = 0;
        bit          exp_err  = 0;
        logic [31:0] sum = 32'd0;
        int unsigned wr0, oob0;
        int          a;
        apply_reset(sel);
        wr0  = n_writes[sel];
        oob0 = n_oob[sel];
        for (int i = 0; i < n; i++) begin
            bit fits = (i < cap);
            apply_stimulus(sel, img[i], i == last_idx, fits, base + 4 * i);
            if (!fits) begin
                exp_err = 1;
                break;
            end
            written++;
            sum += img[i];
            if (i == last_idx) begin
                exp_done = 1;
                break;
            end
            repeat ((gap < 0) ? $urandom_range(0, 3) : gap) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check_output("word_count", 32'(wc_v[sel]), 32'(written));
        check_output("load_done", 32'(done_v[sel]), 32'(exp_done));
        check_output("load_err", 32'(err_v[sel]), 32'(exp_err));
        check_output("ready_end", 32'(ready_v[sel]), 32'(!(exp_done || exp_err)));
        check_output("write_pulses", 32'(n_writes[sel] - wr0), 32'(4 * written));
        check_output("out_of_range", 32'(n_oob[sel] - oob0), 32'd0);
        if (written > 0) check_output("last_addr", last_wr[sel], 32'(base + 4 * written - 1));
        for (int i = 0; i < written; i++) begin
            a = base + 4 * i;
            check_output("mem_word", {mem_obs[sel][a], mem_obs[sel][a+1],
                                      mem_obs[sel][a+2], mem_obs[sel][a+3]}, img[i]);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_output("checksum", cks_v[sel], sum);
`endif
    endtask

    // Holds in_valid high in a terminal state; nothing may be accepted or written.
    task automatic ignore_check(input int sel, input int exp_wc);
        int          seen = 0;
        int unsigned wr0  = n_writes[sel];
        @(negedge clk);
        data         = $urandom;
        last_v[sel]  = 1'b1;
        valid_v[sel] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (ready_v[sel] !== 1'b0) seen++;
        end
        valid_v[sel] = 1'b0;
        check_output("terminal_ready", 32'(seen), 32'd0);
        check_output("terminal_writes", 32'(n_writes[sel] - wr0), 32'd0);
        check_output("terminal_wc", 32'(wc_v[sel]), 32'(exp_wc));
    endtask

    initial begin
        int waited;
        int n;
        int li;
        rst_v   = 2'b11;
        valid_v = 2'b00;
        last_v  = 2'b00;
        data    = 32'd0;
        apply_reset(1);

        $display("[TB] single word");
        img[0] = 32'h02008093;
        run_image(0, 1, 0, 0);

        $display("[TB] stream with stalls");
        img[0] = 32'h00A10113;
        img[1] = 32'h00B18193;
        img[2] = 32'h00C20213;
        run_image(0, 3, 2, 3);

        $display("[TB] overflow on small instance");
        for (int i = 0; i < 3; i++) img[i] = $urandom;
        run_image(1, 3, -1, 1);

        $display("[TB] exact fill on small instance");
        for (int i = 0; i < 2; i++) img[i] = $urandom;
        run_image(1, 2, 1, 0);

        $display("[TB] reset mid-write");
        apply_reset(0);
        img[0] = $urandom;
        apply_stimulus(0, img[0], 1'b0, 1'b1, 0);
        @(negedge clk);
        data       = $urandom;
        last_v[0]  = 1'b1;
        valid_v[0] = 1'b1;
        waited = 0;
        while (ready_v[0] !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check_output("midrst_accept", 32'(waited < 40), 32'd1);
        @(negedge clk);
        valid_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        check_output("midrst_idx2_we", 32'(we_v[0]), 32'd1);
        check_output("midrst_idx2_addr", addr_v[0], 32'd6);
        rst_v[0] = 1'b1;
        @(negedge clk);
        check_output("midrst_we", 32'(we_v[0]), 32'd0);
        check_output("midrst_wc", 32'(wc_v[0]), 32'd0);
        check_output("midrst_ready", 32'(ready_v[0]), 32'd0);
        rst_v[0] = 1'b0;
        @(negedge clk);
        check_output("midrst_ready_after", 32'(ready_v[0]), 32'd1);
        img[0] = $urandom;
        apply_stimulus(0, img[0], 1'b1, 1'b1, 0);
        @(negedge clk);
        check_output("midrst_rewrite", {mem_obs[0][0], mem_obs[0][1], mem_obs[0][2], mem_obs[0][3]}, img[0]);
        check_output("midrst_wc_after", 32'(wc_v[0]), 32'd1);
        check_output("midrst_done", 32'(done_v[0]), 32'd1);

        $display("[TB] non-zero base");
        img[0] = 32'hFFF08093;
        run_image(1, 1, 0, 0);
        ignore_check(1, 1);

        $display("[TB] randomized images");
        for (int r = 0; r < 6; r++) begin
            int sel = r % 2;
            n  = $urandom_range(1, (sel != 0) ? 4 : 24);
            li = $urandom_range(0, n);
            if (li == n) li = -1;
            for (int i = 0; i < n; i++) img[i] = $urandom;
            run_image(sel, n, li, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
